// File: rtl/regfile_arb_pkg.sv
// Shared types and helpers for the register-file write/read arbiters.
package regfile_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Width of an index that selects one of n items (at least 1 bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side and bank-side signals of the register-file write arbiter.
interface regfile_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_gnt;
    logic [NUM_REQ-1:0]            req_done;
    logic                          req_err;
    logic                          reg_wr_en;
    logic [ADDR_WIDTH-1:0]         reg_wr_addr;
    logic [DATA_WIDTH-1:0]         reg_wr_data;
    logic                          reg_wr_ack;

    // Agents and register bank.
    modport master (
        output req_valid, req_addr, req_wdata, reg_wr_ack,
        input  req_gnt, req_done, req_err, reg_wr_en, reg_wr_addr, reg_wr_data
    );

    // Arbiter.
    modport slave (
        input  req_valid, req_addr, req_wdata, reg_wr_ack,
        output req_gnt, req_done, req_err, reg_wr_en, reg_wr_addr, reg_wr_data
    );
endinterface

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first valid bit at or above ptr, with wrap.
module rr_pick
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IDX_W-1:0]   win_idx_o,
    output logic               any_o
);

    // Walk requesters ptr, ptr+1, ... and keep the first one that is valid.
    always_comb begin
        int unsigned        idx;
        logic [NUM_REQ-1:0] rot;
        win_o     = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        rot       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr_i) + i) % NUM_REQ;
            rot = req_valid_i >> idx;
            if (!any_o && rot[0]) begin
                any_o     = 1'b1;
                win_idx_o = IDX_W'(idx);
                win_o     = NUM_REQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among NUM_REQ agents.
module regfile_wr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wr_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = idx_width(ACK_TIMEOUT);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        g_q, g_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    err_q, err_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;

    logic [NUM_REQ-1:0]      win;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_valid_i (bus.req_valid),
        .ptr_i       (ptr_q),
        .win_o       (win),
        .win_idx_o   (win_idx),
        .any_o       (win_any)
    );

    // Next state and next registered outputs; outputs track the state being entered.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        wr_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = WRITE;
                    g_d     = win_idx;
                    cnt_d   = '0;
                    addr_d  = ADDR_WIDTH'(bus.req_addr >> (32'(win_idx) * ADDR_WIDTH));
                    data_d  = DATA_WIDTH'(bus.req_wdata >> (32'(win_idx) * DATA_WIDTH));
                    gnt_d   = win;
                    wr_en_d = 1'b1;
                end
            end
            WRITE: begin
                if (bus.reg_wr_ack) begin
                    state_d = DONE;
                    done_d  = NUM_REQ'(1) << g_q;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_d = DONE;
                    done_d  = NUM_REQ'(1) << g_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    wr_en_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, latches and output registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.req_gnt     = gnt_q;
    assign bus.req_done    = done_q;
    assign bus.req_err     = err_q;
    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_wr_addr = addr_q;
    assign bus.reg_wr_data = data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (4 requesters, 8-bit addr, 32-bit data, timeout 16).
module tb_regfile_wr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [AW-1:0] ta [NR];
    logic [DW-1:0] td [NR];

    regfile_wr_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    regfile_wr_arbiter #(
        .NUM_REQ     (NR),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ta[i] = a;
        td[i] = d;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        return NR'(1) << i;
    endfunction

    initial begin
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.reg_wr_ack = 1'b1;
        set_req(0, 8'h01, 32'h1111_0000);
        set_req(1, 8'h5A, 32'hA5A5_0001);
        set_req(2, 8'h10, 32'hDEAD_BEEF);
        set_req(3, 8'h33, 32'h3333_3333);

        // Reset values
        tick(); tick();
        chk("rst_wr_en", 64'(bus.reg_wr_en), 64'(0));
        chk("rst_gnt",   64'(bus.req_gnt),   64'(0));
        chk("rst_done",  64'(bus.req_done),  64'(0));
        chk("rst_err",   64'(bus.req_err),   64'(0));
        chk("rst_addr",  64'(bus.reg_wr_addr), 64'(0));
        chk("rst_data",  64'(bus.reg_wr_data), 64'(0));

        // Single request from requester 2, ack tied high
        rst = 1'b0;
        bus.req_valid = 4'b0100;
        tick();
        chk("t1_wr_en", 64'(bus.reg_wr_en),   64'(1));
        chk("t1_gnt",   64'(bus.req_gnt),     64'(4'b0100));
        chk("t1_addr",  64'(bus.reg_wr_addr), 64'(8'h10));
        chk("t1_data",  64'(bus.reg_wr_data), 64'(32'hDEAD_BEEF));
        chk("t1_done0", 64'(bus.req_done),    64'(0));
        bus.req_valid = '0;
        tick();
        chk("t1_done",  64'(bus.req_done),    64'(4'b0100));
        chk("t1_err",   64'(bus.req_err),     64'(0));
        chk("t1_wr_en_off", 64'(bus.reg_wr_en), 64'(0));
        chk("t1_gnt_off",   64'(bus.req_gnt),   64'(0));
        chk("t1_addr_hold", 64'(bus.reg_wr_addr), 64'(8'h10));
        tick();
        chk("t1_idle_done", 64'(bus.req_done), 64'(0));

        // Reset to bring the pointer back to 0, then all requesters continuously valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("fair_gnt",  64'(bus.req_gnt),     64'(oh(k % NR)));
            chk("fair_addr", 64'(bus.reg_wr_addr), 64'(ta[k % NR]));
            chk("fair_data", 64'(bus.reg_wr_data), 64'(td[k % NR]));
            tick();
            chk("fair_done", 64'(bus.req_done),    64'(oh(k % NR)));
            tick();
            chk("fair_idle_gnt", 64'(bus.req_gnt), 64'(0));
        end
        bus.req_valid = '0;

        // Delayed ack on the third WRITE cycle (pointer now at 1)
        bus.reg_wr_ack = 1'b0;
        bus.req_valid  = 4'b0010;
        tick();
        chk("dly_gnt",    64'(bus.req_gnt),   64'(4'b0010));
        chk("dly_wr_en0", 64'(bus.reg_wr_en), 64'(1));
        bus.req_valid = '0;
        tick();
        chk("dly_wr_en1", 64'(bus.reg_wr_en), 64'(1));
        chk("dly_gnt1",   64'(bus.req_gnt),   64'(0));
        tick();
        chk("dly_wr_en2", 64'(bus.reg_wr_en), 64'(1));
        chk("dly_done2",  64'(bus.req_done),  64'(0));
        bus.reg_wr_ack = 1'b1;
        tick();
        chk("dly_wr_en3", 64'(bus.reg_wr_en), 64'(0));
        chk("dly_done",   64'(bus.req_done),  64'(4'b0010));
        chk("dly_err",    64'(bus.req_err),   64'(0));
        bus.reg_wr_ack = 1'b0;
        tick();

        // Timeout on requester 2 (pointer at 2); 0 and 3 wait meanwhile
        set_req(2, 8'h30, 32'hCAFE_F00D);
        bus.req_valid = 4'b0100;
        tick();
        chk("to_gnt",   64'(bus.req_gnt),     64'(4'b0100));
        chk("to_wr_en", 64'(bus.reg_wr_en),   64'(1));
        bus.req_valid = 4'b1001;
        for (int i = 1; i < int'(TO); i++) begin
            tick();
            chk("to_wr_en_hold", 64'(bus.reg_wr_en), 64'(1));
            chk("to_no_done",    64'(bus.req_done),  64'(0));
        end
        tick();
        chk("to_wr_en_off", 64'(bus.reg_wr_en),   64'(0));
        chk("to_done",      64'(bus.req_done),    64'(4'b0100));
        chk("to_err",       64'(bus.req_err),     64'(1));
        chk("to_addr_hold", 64'(bus.reg_wr_addr), 64'(8'h30));
        chk("to_data_hold", 64'(bus.reg_wr_data), 64'(32'hCAFE_F00D));
        tick();
        chk("to_idle_err", 64'(bus.req_err), 64'(0));
        tick();
        chk("to_next_gnt", 64'(bus.req_gnt), 64'(4'b1000));
        bus.reg_wr_ack = 1'b1;
        bus.req_valid  = 4'b0001;
        tick();
        chk("to_next_done", 64'(bus.req_done), 64'(4'b1000));
        chk("to_next_err",  64'(bus.req_err),  64'(0));
        tick();
        tick();
        chk("wrap_gnt", 64'(bus.req_gnt), 64'(4'b0001));
        bus.req_valid = '0;
        tick();
        tick();

        // Reset in the second WRITE cycle (pointer at 1)
        bus.reg_wr_ack = 1'b0;
        bus.req_valid  = 4'b0010;
        tick();
        chk("rmw_gnt", 64'(bus.req_gnt), 64'(4'b0010));
        bus.req_valid = '0;
        tick();
        chk("rmw_wr_en", 64'(bus.reg_wr_en), 64'(1));
        rst = 1'b1;
        tick();
        chk("rmw_wr_en0", 64'(bus.reg_wr_en),   64'(0));
        chk("rmw_gnt0",   64'(bus.req_gnt),     64'(0));
        chk("rmw_done0",  64'(bus.req_done),    64'(0));
        chk("rmw_err0",   64'(bus.req_err),     64'(0));
        chk("rmw_addr0",  64'(bus.reg_wr_addr), 64'(0));
        chk("rmw_data0",  64'(bus.reg_wr_data), 64'(0));
        rst = 1'b0;
        bus.reg_wr_ack = 1'b1;
        tick();
        chk("rmw_no_done", 64'(bus.req_done), 64'(0));
        bus.req_valid = 4'b0011;
        tick();
        chk("rmw_ptr0_gnt", 64'(bus.req_gnt), 64'(4'b0001));
        bus.req_valid = 4'b0010;
        tick();
        chk("rmw_done_r0", 64'(bus.req_done), 64'(4'b0001));
        tick();
        tick();
        chk("rmw_gnt_r1", 64'(bus.req_gnt),     64'(4'b0010));
        chk("rmw_addr1",  64'(bus.reg_wr_addr), 64'(8'h5A));
        bus.req_valid = '0;
        tick();
        tick();

        // Late valid: requester 1 raises valid while requester 0 is writing (pointer at 2)
        bus.reg_wr_ack = 1'b0;
        bus.req_valid  = 4'b0001;
        tick();
        chk("late_gnt0", 64'(bus.req_gnt), 64'(4'b0001));
        bus.req_valid = 4'b0010;
        tick();
        chk("late_ignored", 64'(bus.req_gnt),   64'(0));
        chk("late_wr_en",   64'(bus.reg_wr_en), 64'(1));
        bus.reg_wr_ack = 1'b1;
        tick();
        chk("late_done0", 64'(bus.req_done), 64'(4'b0001));
        chk("late_gnt_dn", 64'(bus.req_gnt), 64'(0));
        tick();
        chk("late_idle_gnt", 64'(bus.req_gnt), 64'(0));
        tick();
        chk("late_gnt1", 64'(bus.req_gnt), 64'(4'b0010));
        bus.req_valid = '0;
        tick();
        chk("late_done1", 64'(bus.req_done), 64'(4'b0010));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Round-robin write arbiter sharing a single register-bank write port between `NUM_REQ` requesters. It accepts one write at a time, latches its address and data, and drives a write strobe into the bank of reset-valued flops. It holds the strobe until the bank acknowledges or a timeout expires, then reports completion per requester. It sits between bus-side agents (CPU slave, debug port, hardware update logic) and the generated register file.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 8: register address width.
- `DATA_WIDTH`, 32: register data width.
- `ACK_TIMEOUT`, 16: maximum number of WRITE cycles to wait for `reg_wr_ack`, 2..255.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  flattened; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  flattened, same packing as `req_addr`.
- `req_gnt`  out  NUM_REQ  one-hot, 1-cycle pulse; the request has been latched.
- `req_done`  out  NUM_REQ  one-hot, 1-cycle pulse; the write is finished.
- `req_err`  out  1  high together with `req_done` when the write timed out.
- `reg_wr_en`  out  1  write strobe to the register bank.
- `reg_wr_addr`  out  ADDR_WIDTH  latched address.
- `reg_wr_data`  out  DATA_WIDTH  latched data.
- `reg_wr_ack`  in  1  bank accepted the write; tie to 1 for single-cycle flops.

## Operation
- FSM states: IDLE, WRITE, DONE. All outputs are registered.
- IDLE:
  - Arbitrate only in this state.
  - Winner: the first set `req_valid` bit, searching upward (with wrap) from `ptr`.
  - On a win: latch the winner's addr/data into `reg_wr_addr`/`reg_wr_data`, record the index `g`, clear the timeout counter, go to WRITE.
  - With no valid requests: stay in IDLE.
- WRITE:
  - `reg_wr_en`=1 throughout.
  - `req_gnt[g]`=1 in the first WRITE cycle only.
  - If `reg_wr_ack`=1: go to DONE with `req_err`=0.
  - Otherwise increment the counter. If the counter reaches ACK_TIMEOUT-1 without an ack, go to DONE with `req_err`=1.
- DONE:
  - `reg_wr_en`=0, `req_done[g]`=1, `req_err` as decided in WRITE.
  - `ptr` ← (g+1) mod NUM_REQ.
  - Go to IDLE.
- Requester rule: hold `req_valid` until `req_gnt` is sampled, then deassert it within 1 cycle. Addr/data may change after the grant.
- A requester that keeps `req_valid` high through DONE is treated as a new request.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,…,NUM_REQ-1,0.
- A valid requester waits for at most NUM_REQ-1 other writes before its grant.
- Reset:
  - `rst`=1 forces IDLE and `ptr`=0.
  - All outputs go to 0, including addr and data.
  - Reset takes priority in any state. An in-flight write is abandoned with no `req_done`.
- `req_valid` bits that change while the FSM is outside IDLE have no effect.

## Timing
- Request seen at edge N (IDLE) → `reg_wr_en`, `req_gnt` high in cycle N+1.
- With ack tied high: WRITE lasts 1 cycle, DONE is in cycle N+2, IDLE in N+3. Total 3 cycles per write.
- Back-to-back throughput is one write per 3 cycles.
- Ack arriving k cycles into WRITE (k=0 is the first WRITE cycle): DONE follows at WRITE start+k+1.
- Timeout: WRITE lasts exactly ACK_TIMEOUT cycles, then DONE with `req_err`=1.
- An ack on the last WRITE cycle wins over the timeout, giving `req_err`=0.
- `reg_wr_addr`/`reg_wr_data` are stable from the first WRITE cycle through DONE.

## Structure
- Shared package `regfile_arb_pkg` holds:
  - the FSM state encoding (IDLE=2'd0, WRITE=2'd1, DONE=2'd2);
  - the `clog2`-based index-width function used for `ptr` and `g`.
- Sub-module `rr_pick`: combinational rotate-priority encoder.
  - Inputs: `req_valid`, `ptr`.
  - Outputs: one-hot `win`, `win_idx`, `any`.
  - Reusable by the read-path arbiter.
- The top level contains the FSM, the latches, the timeout counter and the pointer update.

## Test plan
- Single request, ack tied 1: `req_valid[2]`=1, addr 0x10, data 0xDEADBEEF → cycle 1 `reg_wr_en`=1, addr 0x10, data 0xDEADBEEF, `req_gnt`=4'b0100; cycle 2 `req_done`=4'b0100, `req_err`=0.
- All 4 valid continuously, ack=1 → grants in order 0,1,2,3,0, each 3 cycles apart; no requester starves.
- Delayed ack: ack raised on the 3rd WRITE cycle → `reg_wr_en` high for exactly 3 cycles, then `req_done`, `req_err`=0.
- Timeout: ack held 0, ACK_TIMEOUT=16 → `reg_wr_en` high for exactly 16 cycles, then `req_done` with `req_err`=1; the next grant goes to index g+1.
- Reset mid-write: assert `rst` in the 2nd WRITE cycle → next cycle all outputs 0, no `req_done`; the next arbitration starts from index 0.
- Late valid: `req_valid[1]` rises during WRITE for requester 0 → ignored until IDLE, then granted immediately.
